// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// Carries the stage stall requests, exception info, and the stall/flush controls.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_err;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_if,
        output stallreq_id,
        output stallreq_ex,
        output stallreq_mem,
        output excepttype_i,
        output cp0_epc_i,
        input  stall,
        input  flush,
        input  new_pc,
        input  bus_err,
        input  stall_cycles
    );

    modport slave (
        input  stallreq_if,
        input  stallreq_id,
        input  stallreq_ex,
        input  stallreq_mem,
        input  excepttype_i,
        input  cp0_epc_i,
        output stall,
        output flush,
        output new_pc,
        output bus_err,
        output stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, exception flush with a one-cycle
// quiesce, memory-bus wait timeout and a stalled-cycle counter.
module pipe_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 255,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned     CntW    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(BUS_TIMEOUT - 1);
    localparam logic [31:0]     ExcEret = 32'h0000_000e;

    typedef enum logic [0:0] {StRun, StQuiesce} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    // Outputs are forced to zero while reset is held, independent of the requests.
    always_comb begin
        stall   = 6'b000000;
        flush   = 1'b0;
        new_pc  = 32'h0;
        state_d = StRun;
        if (!rst && state_q == StRun) begin
            if (bus.excepttype_i != 32'h0) begin
                flush   = 1'b1;
                new_pc  = (bus.excepttype_i == ExcEret) ? bus.cp0_epc_i : EXC_VECTOR;
                state_d = StQuiesce;
            end else if (bus.stallreq_mem) begin
                stall = 6'b011111;
            end else if (bus.stallreq_ex) begin
                stall = 6'b001111;
            end else if (bus.stallreq_id) begin
                stall = 6'b000111;
            end else if (bus.stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    // stall[4] is only set when the memory request wins in RUN with no exception.
    always_comb begin
        cnt_d     = '0;
        bus_err_d = 1'b0;
        if (stall[4]) begin
            if (cnt_q == CntMax) begin
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        stall_cycles_d = stall_cycles_q + 32'(stall[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StRun;
            cnt_q          <= '0;
            bus_err_q      <= 1'b0;
            stall_cycles_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_err_q      <= bus_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.flush        = flush;
    assign bus.new_pc       = new_pc;
    assign bus.bus_err      = bus_err_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus,
// compared against a behavioural model tracking quiesce, mem-wait streak and counts.
module tb_pipe_ctrl;
    localparam int unsigned BusTimeout = 4;
    localparam logic [31:0] ExcVector  = 32'h0000_0020;

    logic clk = 1'b0;
    logic rst;

    pipe_ctrl_if bus_if ();

    pipe_ctrl #(
        .BUS_TIMEOUT(BusTimeout),
        .EXC_VECTOR (ExcVector)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Behavioural model state
    bit          m_quiesce;
    int unsigned m_streak;
    bit          m_bus_err;
    logic [31:0] m_stall_cycles;
    int unsigned pulses;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_quiesce      = 1'b0;
        m_streak       = 0;
        m_bus_err      = 1'b0;
        m_stall_cycles = 32'h0;
    endtask

    // Applies inputs for one cycle, checks combinational outputs, then the registered ones.
    task automatic step(input bit r_if, input bit r_id, input bit r_ex, input bit r_mem,
                        input logic [31:0] exc, input logic [31:0] epc);
        int unsigned depth;
        bit          exc_taken;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        bus_if.stallreq_if  = r_if;
        bus_if.stallreq_id  = r_id;
        bus_if.stallreq_ex  = r_ex;
        bus_if.stallreq_mem = r_mem;
        bus_if.excepttype_i = exc;
        bus_if.cp0_epc_i    = epc;
        #2;
        depth     = 0;
        e_flush   = 1'b0;
        e_pc      = 32'h0;
        exc_taken = !m_quiesce && (exc != 32'h0);
        if (exc_taken) begin
            e_flush = 1'b1;
            e_pc    = (exc == 32'h0000_000e) ? epc : ExcVector;
        end else if (!m_quiesce) begin
            // Number of frozen pipeline stages, counted from the PC upward.
            depth = r_mem ? 5 : r_ex ? 4 : r_id ? 3 : r_if ? 2 : 0;
        end
        e_stall = 6'((1 << depth) - 1);
        check_eq("stall", 32'(bus_if.stall), 32'(e_stall));
        check_eq("flush", 32'(bus_if.flush), 32'(e_flush));
        check_eq("new_pc", bus_if.new_pc, e_pc);

        if (depth == 5) m_streak++;
        else m_streak = 0;
        m_bus_err = 1'b0;
        if (m_streak == BusTimeout) begin
            m_bus_err = 1'b1;
            m_streak  = 0;
        end
        if (depth != 0) m_stall_cycles++;
        m_quiesce = exc_taken;

        @(posedge clk);
        #1;
        check_eq("bus_err", 32'(bus_if.bus_err), 32'(m_bus_err));
        check_eq("stall_cycles", bus_if.stall_cycles, m_stall_cycles);
        if (bus_if.bus_err === 1'b1) pulses++;
    endtask

    // Asynchronous reset asserted away from the clock edge with requests still active.
    task automatic async_reset(input string tag);
        #2;
        bus_if.stallreq_mem = 1'b1;
        bus_if.stallreq_ex  = 1'b1;
        rst = 1'b1;
        #1;
        check_eq({tag, "_stall"}, 32'(bus_if.stall), 32'h0);
        check_eq({tag, "_flush"}, 32'(bus_if.flush), 32'h0);
        check_eq({tag, "_new_pc"}, bus_if.new_pc, 32'h0);
        check_eq({tag, "_bus_err"}, 32'(bus_if.bus_err), 32'h0);
        check_eq({tag, "_stall_cycles"}, bus_if.stall_cycles, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_hold_bus_err"}, 32'(bus_if.bus_err), 32'h0);
        check_eq({tag, "_hold_stall"}, 32'(bus_if.stall), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        bus_if.stallreq_if  = 1'b0;
        bus_if.stallreq_id  = 1'b0;
        bus_if.stallreq_ex  = 1'b0;
        bus_if.stallreq_mem = 1'b0;
        bus_if.excepttype_i = 32'h0;
        bus_if.cp0_epc_i    = 32'h0;
        pulses              = 0;
        model_reset();
        #12;
        check_eq("rst_stall", 32'(bus_if.stall), 32'h0);
        check_eq("rst_flush", 32'(bus_if.flush), 32'h0);
        check_eq("rst_new_pc", bus_if.new_pc, 32'h0);
        check_eq("rst_bus_err", 32'(bus_if.bus_err), 32'h0);
        check_eq("rst_stall_cycles", bus_if.stall_cycles, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stall priority
        step(0, 1, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 0, 32'h0, 32'h0);
        step(0, 1, 1, 1, 32'h0, 32'h0);
        check_eq("prio_stall_cycles", bus_if.stall_cycles, 32'd3);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);

        // Exception flush, quiesce, resume
        step(0, 0, 1, 0, 32'h1, 32'h0);
        step(0, 1, 0, 0, 32'h1, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);

        // eret
        step(0, 0, 0, 0, 32'h0000_000e, 32'h0000_1234);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Bus timeout: held for 8 edges gives two pulses
        pulses = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("timeout_pulses_held", pulses, 32'd2);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        // Drop after 3, re-raise: pulse only after 4 further stalled edges
        pulses = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("timeout_no_early_pulse", pulses, 32'd0);
        step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("timeout_restart_pulse", pulses, 32'd1);

        // Exception on the 4th stalled cycle beats the timeout
        pulses = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h5, 32'h0);
        step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("exc_beats_timeout", pulses, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("exc_counter_restart", pulses, 32'd1);

        // Reset during QUIESCE
        step(0, 0, 0, 0, 32'h3, 32'h0);
        async_reset("rst_quiesce");
        step(0, 1, 0, 0, 32'h0, 32'h0);

        // Reset mid-count, then a full timeout is required again
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        async_reset("rst_count");
        pulses = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("rst_count_no_pulse", pulses, 32'd0);
        step(0, 0, 0, 1, 32'h0, 32'h0);
        check_eq("rst_count_full_pulse", pulses, 32'd1);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] exc;
            exc = 32'h0;
            if ($urandom_range(15) == 0) begin
                exc = ($urandom_range(3) == 0) ? 32'h0000_000e : ($urandom() | 32'h1);
            end
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                 1'($urandom_range(9) < 7), exc, $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
